// File: rtl/pe_seq_pkg.sv
// Shared types and width helpers for the pe_array sequencer.
package pe_seq_pkg;

  // Counter/address width for a range of n values; never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    FLUSH = 3'd2,
    CLEAR = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } pe_state_e;

  localparam int DEF_MAC_NUM    = 10;
  localparam int DEF_IA_H       = 100;
  localparam int DEF_IA_W       = 150;
  localparam int DEF_OA_W       = 16;
  localparam int DEF_RESULT_LAT = 2;

  localparam int DEF_BLK_W  = cnt_w(DEF_IA_H / DEF_MAC_NUM);
  localparam int DEF_COL_W  = cnt_w(DEF_IA_W);
  localparam int DEF_OCOL_W = cnt_w(DEF_OA_W);
  localparam int DEF_LAT_W  = cnt_w(DEF_RESULT_LAT);

endpackage

// File: rtl/pe_array_seq_ctrl_counter.sv
// Three-level loop counter: reduction index i (inner), row block j, output
// column m (outer). inc_inner steps i; inc_tile resets i and steps j/m.
module pe_loop_counter
  import pe_seq_pkg::*;
#(
  parameter int N_I = DEF_IA_W,
  parameter int N_J = DEF_IA_H / DEF_MAC_NUM,
  parameter int N_M = DEF_OA_W,
  localparam int IW = cnt_w(N_I),
  localparam int JW = cnt_w(N_J),
  localparam int MW = cnt_w(N_M)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc_inner,
  input  logic          inc_tile,
  output logic [IW-1:0] i,
  output logic [JW-1:0] j,
  output logic [MW-1:0] m,
  output logic          last_i,
  output logic          last_tile
);

  logic last_j;
  logic last_m;

  assign last_i    = (i == IW'(N_I - 1));
  assign last_j    = (j == JW'(N_J - 1));
  assign last_m    = (m == MW'(N_M - 1));
  assign last_tile = last_j & last_m;

  // Tile advance has priority over the inner step; both wrap to zero.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      i <= '0;
      j <= '0;
      m <= '0;
    end else if (inc_tile) begin
      i <= '0;
      if (last_j) begin
        j <= '0;
        m <= last_m ? '0 : m + 1'b1;
      end else begin
        j <= j + 1'b1;
      end
    end else if (inc_inner) begin
      i <= last_i ? '0 : i + 1'b1;
    end
  end

endmodule

// File: rtl/pe_array_seq_ctrl.sv
// Sequencer for the pe_array compute port: streams operands tile by tile,
// clears accumulators between tiles and writes each tile result out.
// Write handshake: a write transfers on a cycle where oa_wr_valid and
// oa_wr_ready are both high; once raised, oa_wr_valid, address and data stay
// constant until that cycle, and ready may toggle freely.
module pe_array_seq_ctrl
  import pe_seq_pkg::*;
#(
  parameter int MAC_NUM    = DEF_MAC_NUM,
  parameter int BW_ACT     = 8,
  parameter int BW_WET     = 8,
  parameter int IA_H       = DEF_IA_H,
  parameter int IA_W       = DEF_IA_W,
  parameter int OA_W       = DEF_OA_W,
  parameter int RESULT_LAT = DEF_RESULT_LAT,
  localparam int BLK_W  = cnt_w(IA_H / MAC_NUM),
  localparam int COL_W  = cnt_w(IA_W),
  localparam int OCOL_W = cnt_w(OA_W),
  localparam int LAT_W  = cnt_w(RESULT_LAT),
  localparam int DW     = MAC_NUM * BW_ACT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        shift_num,
  output logic              busy,
  output logic              done,
  output logic              act_rd_en,
  output logic [BLK_W-1:0]  act_rd_blk,
  output logic [COL_W-1:0]  act_rd_col,
  input  logic [DW-1:0]     act_rd_data,
  output logic              wet_rd_en,
  output logic [COL_W-1:0]  wet_rd_row,
  output logic [OCOL_W-1:0] wet_rd_col,
  input  logic [BW_WET-1:0] wet_rd_data,
  output logic              PE_mac_enable,
  output logic              PE_clear_acc,
  output logic [DW-1:0]     PE_act_in,
  output logic [BW_WET-1:0] PE_wet_in,
  output logic [7:0]        PE_res_shift_num,
  input  logic [DW-1:0]     PE_result_in,
  output logic              oa_wr_valid,
  input  logic              oa_wr_ready,
  output logic [BLK_W-1:0]  oa_wr_blk,
  output logic [OCOL_W-1:0] oa_wr_col,
  output logic [DW-1:0]     oa_wr_data,
  output pe_state_e         fsm_state
);

  if (IA_H % MAC_NUM != 0) begin : g_bad_ia_h
    $error("IA_H must be a multiple of MAC_NUM");
  end

  pe_state_e         state_q, state_d;
  logic [7:0]        shift_q;
  logic              mac_en_q;
  logic [LAT_W-1:0]  lat_q;
  logic              rd_en, inc_inner, inc_tile, cnt_clr;
  logic              clear, wr_valid, busy_c, done_c;
  logic [COL_W-1:0]  cnt_i;
  logic [BLK_W-1:0]  cnt_j;
  logic [OCOL_W-1:0] cnt_m;
  logic              last_i, last_tile;

  pe_loop_counter #(
    .N_I (IA_W),
    .N_J (IA_H / MAC_NUM),
    .N_M (OA_W)
  ) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .clr       (cnt_clr),
    .inc_inner (inc_inner),
    .inc_tile  (inc_tile),
    .i         (cnt_i),
    .j         (cnt_j),
    .m         (cnt_m),
    .last_i    (last_i),
    .last_tile (last_tile)
  );

  // State register, latched shift, operand-valid pipeline and clear-phase timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      mac_en_q <= 1'b0;
      lat_q    <= '0;
    end else begin
      state_q  <= state_d;
      mac_en_q <= rd_en;
      if (state_q == IDLE && start) shift_q <= shift_num;
      lat_q    <= (state_q == CLEAR) ? lat_q + 1'b1 : '0;
    end
  end

  // Next-state and per-state controls.
  always_comb begin
    state_d   = state_q;
    rd_en     = 1'b0;
    inc_inner = 1'b0;
    inc_tile  = 1'b0;
    cnt_clr   = 1'b0;
    clear     = 1'b0;
    wr_valid  = 1'b0;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_clr = 1'b1;
        end
      end
      RUN: begin
        busy_c    = 1'b1;
        rd_en     = 1'b1;
        inc_inner = 1'b1;
        if (last_i) state_d = FLUSH;
      end
      FLUSH: begin
        busy_c  = 1'b1;
        state_d = CLEAR;
      end
      CLEAR: begin
        busy_c = 1'b1;
        clear  = 1'b1;
        if (lat_q == LAT_W'(RESULT_LAT - 1)) state_d = WRITE;
      end
      WRITE: begin
        busy_c   = 1'b1;
        clear    = 1'b1;
        wr_valid = 1'b1;
        if (oa_wr_ready) begin
          inc_tile = 1'b1;
          state_d  = last_tile ? DONE : RUN;
        end
      end
      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy             = busy_c;
  assign done             = done_c;
  assign act_rd_en        = rd_en;
  assign act_rd_blk       = rd_en ? cnt_j : '0;
  assign act_rd_col       = rd_en ? cnt_i : '0;
  assign wet_rd_en        = rd_en;
  assign wet_rd_row       = rd_en ? cnt_i : '0;
  assign wet_rd_col       = rd_en ? cnt_m : '0;
  assign PE_mac_enable    = mac_en_q;
  assign PE_clear_acc     = clear;
  assign PE_act_in        = mac_en_q ? act_rd_data : '0;
  assign PE_wet_in        = mac_en_q ? wet_rd_data : '0;
  assign PE_res_shift_num = shift_q;
  assign oa_wr_valid      = wr_valid;
  assign oa_wr_blk        = wr_valid ? cnt_j : '0;
  assign oa_wr_col        = wr_valid ? cnt_m : '0;
  assign oa_wr_data       = wr_valid ? PE_result_in : '0;
  assign fsm_state        = state_q;

endmodule

// File: tb/tb_pe_array_seq_ctrl.sv
// Bench for pe_array_seq_ctrl: a default-size instance and a small instance,
// each with behavioural SRAMs and a behavioural pe_array.
module tb_pe_array_seq_ctrl;
  import pe_seq_pkg::*;

  localparam int MAC = 10, IAH = 100, IAW = 150, OAW = 16, LAT = 2;
  localparam int NB = IAH / MAC;
  localparam int BLK_W = cnt_w(NB), COL_W = cnt_w(IAW), OCOL_W = cnt_w(OAW);
  localparam int DW = MAC * 8;
  localparam int EW = BLK_W + OCOL_W + DW;
  localparam int TILE_P = IAW + LAT + 2;
  localparam int LAYER_CYC = OAW * NB * TILE_P;

  localparam int S_MAC = 4, S_IAH = 8, S_IAW = 3, S_OAW = 2;
  localparam int S_NB = S_IAH / S_MAC;
  localparam int S_BLK_W = cnt_w(S_NB), S_COL_W = cnt_w(S_IAW), S_OCOL_W = cnt_w(S_OAW);
  localparam int S_DW = S_MAC * 8;
  localparam int S_EW = S_BLK_W + S_OCOL_W + S_DW;
  localparam int S_TILE_P = S_IAW + LAT + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errs = 0;

  // ---------------- default instance ----------------
  logic              start;
  logic [7:0]        shift_num;
  logic              busy, done;
  logic              act_rd_en, wet_rd_en;
  logic [BLK_W-1:0]  act_rd_blk, oa_wr_blk;
  logic [COL_W-1:0]  act_rd_col, wet_rd_row;
  logic [OCOL_W-1:0] wet_rd_col, oa_wr_col;
  logic [DW-1:0]     act_rd_data, PE_act_in, PE_result_in, oa_wr_data;
  logic [7:0]        wet_rd_data, PE_wet_in, PE_res_shift_num;
  logic              PE_mac_enable, PE_clear_acc, oa_wr_valid, oa_wr_ready;
  pe_state_e         fsm_state;
  logic [255:0]      outs;
  logic [EW-1:0]     exp_q[$];

  pe_array_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .shift_num(shift_num),
    .busy(busy), .done(done),
    .act_rd_en(act_rd_en), .act_rd_blk(act_rd_blk), .act_rd_col(act_rd_col), .act_rd_data(act_rd_data),
    .wet_rd_en(wet_rd_en), .wet_rd_row(wet_rd_row), .wet_rd_col(wet_rd_col), .wet_rd_data(wet_rd_data),
    .PE_mac_enable(PE_mac_enable), .PE_clear_acc(PE_clear_acc), .PE_act_in(PE_act_in),
    .PE_wet_in(PE_wet_in), .PE_res_shift_num(PE_res_shift_num), .PE_result_in(PE_result_in),
    .oa_wr_valid(oa_wr_valid), .oa_wr_ready(oa_wr_ready), .oa_wr_blk(oa_wr_blk),
    .oa_wr_col(oa_wr_col), .oa_wr_data(oa_wr_data), .fsm_state(fsm_state)
  );

  assign outs = 256'({busy, done, act_rd_en, act_rd_blk, act_rd_col, wet_rd_en, wet_rd_row,
                       wet_rd_col, PE_mac_enable, PE_clear_acc, PE_act_in, PE_wet_in,
                       PE_res_shift_num, oa_wr_valid, oa_wr_blk, oa_wr_col, oa_wr_data});

  // ---------------- small instance ----------------
  logic                s_start;
  logic [7:0]          s_shift_num;
  logic                s_busy, s_done;
  logic                s_act_rd_en, s_wet_rd_en;
  logic [S_BLK_W-1:0]  s_act_rd_blk, s_oa_wr_blk;
  logic [S_COL_W-1:0]  s_act_rd_col, s_wet_rd_row;
  logic [S_OCOL_W-1:0] s_wet_rd_col, s_oa_wr_col;
  logic [S_DW-1:0]     s_act_rd_data, s_PE_act_in, s_PE_result_in, s_oa_wr_data;
  logic [7:0]          s_wet_rd_data, s_PE_wet_in, s_PE_res_shift_num;
  logic                s_PE_mac_enable, s_PE_clear_acc, s_oa_wr_valid, s_oa_wr_ready;
  pe_state_e           s_fsm_state;
  logic [255:0]        s_outs;
  logic [S_EW-1:0]     s_exp_q[$];

  pe_array_seq_ctrl #(.MAC_NUM(S_MAC), .IA_H(S_IAH), .IA_W(S_IAW), .OA_W(S_OAW), .RESULT_LAT(LAT)) dut_s (
    .clk(clk), .reset(reset), .start(s_start), .shift_num(s_shift_num),
    .busy(s_busy), .done(s_done),
    .act_rd_en(s_act_rd_en), .act_rd_blk(s_act_rd_blk), .act_rd_col(s_act_rd_col), .act_rd_data(s_act_rd_data),
    .wet_rd_en(s_wet_rd_en), .wet_rd_row(s_wet_rd_row), .wet_rd_col(s_wet_rd_col), .wet_rd_data(s_wet_rd_data),
    .PE_mac_enable(s_PE_mac_enable), .PE_clear_acc(s_PE_clear_acc), .PE_act_in(s_PE_act_in),
    .PE_wet_in(s_PE_wet_in), .PE_res_shift_num(s_PE_res_shift_num), .PE_result_in(s_PE_result_in),
    .oa_wr_valid(s_oa_wr_valid), .oa_wr_ready(s_oa_wr_ready), .oa_wr_blk(s_oa_wr_blk),
    .oa_wr_col(s_oa_wr_col), .oa_wr_data(s_oa_wr_data), .fsm_state(s_fsm_state)
  );

  assign s_outs = 256'({s_busy, s_done, s_act_rd_en, s_act_rd_blk, s_act_rd_col, s_wet_rd_en,
                         s_wet_rd_row, s_wet_rd_col, s_PE_mac_enable, s_PE_clear_acc, s_PE_act_in,
                         s_PE_wet_in, s_PE_res_shift_num, s_oa_wr_valid, s_oa_wr_blk,
                         s_oa_wr_col, s_oa_wr_data});

  // ---------------- memory contents ----------------
  function automatic int act_val(input int row, input int col);
    return (row * 3 + col * 5 + 1) % 16;
  endfunction

  function automatic int wet_val(input int row, input int col);
    return (row * 7 + col * 11 + 2) % 16;
  endfunction

  // Default-instance SRAMs, one-cycle read latency.
  always @(posedge clk) begin
    if (act_rd_en)
      for (int n = 0; n < MAC; n++)
        act_rd_data[n*8 +: 8] <= 8'(act_val(int'(act_rd_blk) * MAC + n, int'(act_rd_col)));
    if (wet_rd_en) wet_rd_data <= 8'(wet_val(int'(wet_rd_row), int'(wet_rd_col)));
  end

  // Small-instance SRAMs.
  always @(posedge clk) begin
    if (s_act_rd_en)
      for (int n = 0; n < S_MAC; n++)
        s_act_rd_data[n*8 +: 8] <= 8'(act_val(int'(s_act_rd_blk) * S_MAC + n, int'(s_act_rd_col)));
    if (s_wet_rd_en) s_wet_rd_data <= 8'(wet_val(int'(s_wet_rd_row), int'(s_wet_rd_col)));
  end

  // ---------------- behavioural pe_array models ----------------
  // Result shows junk right after clear rises and becomes valid LAT cycles
  // after the first clear cycle, then holds while clear stays high.
  int unsigned acc [MAC];
  int unsigned snap [MAC];
  int          clr_run;
  always @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < MAC; n++) acc[n] = 0;
      clr_run = 0;
      PE_result_in <= '0;
    end else begin
      if (PE_mac_enable)
        for (int n = 0; n < MAC; n++)
          acc[n] = acc[n] + 32'(PE_act_in[n*8 +: 8]) * 32'(PE_wet_in);
      if (PE_clear_acc) begin
        if (clr_run == 0) begin
          for (int n = 0; n < MAC; n++) begin snap[n] = acc[n]; acc[n] = 0; end
          PE_result_in <= '1;
        end
        if (clr_run == LAT - 1)
          for (int n = 0; n < MAC; n++) PE_result_in[n*8 +: 8] <= 8'(snap[n] >> PE_res_shift_num);
        clr_run++;
      end else begin
        clr_run = 0;
      end
    end
  end

  int unsigned s_acc [S_MAC];
  int unsigned s_snap [S_MAC];
  int          s_clr_run;
  always @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < S_MAC; n++) s_acc[n] = 0;
      s_clr_run = 0;
      s_PE_result_in <= '0;
    end else begin
      if (s_PE_mac_enable)
        for (int n = 0; n < S_MAC; n++)
          s_acc[n] = s_acc[n] + 32'(s_PE_act_in[n*8 +: 8]) * 32'(s_PE_wet_in);
      if (s_PE_clear_acc) begin
        if (s_clr_run == 0) begin
          for (int n = 0; n < S_MAC; n++) begin s_snap[n] = s_acc[n]; s_acc[n] = 0; end
          s_PE_result_in <= '1;
        end
        if (s_clr_run == LAT - 1)
          for (int n = 0; n < S_MAC; n++) s_PE_result_in[n*8 +: 8] <= 8'(s_snap[n] >> s_PE_res_shift_num);
        s_clr_run++;
      end else begin
        s_clr_run = 0;
      end
    end
  end

  // ---------------- expected-result generation ----------------
  function automatic logic [DW-1:0] exp_tile(input int j, input int m, input int sh);
    logic [DW-1:0] r;
    int unsigned   s;
    for (int n = 0; n < MAC; n++) begin
      s = 0;
      for (int i = 0; i < IAW; i++) s += act_val(j * MAC + n, i) * wet_val(i, m);
      r[n*8 +: 8] = 8'(s >> sh);
    end
    return r;
  endfunction

  function automatic logic [S_DW-1:0] s_exp_tile(input int j, input int m, input int sh);
    logic [S_DW-1:0] r;
    int unsigned     s;
    for (int n = 0; n < S_MAC; n++) begin
      s = 0;
      for (int i = 0; i < S_IAW; i++) s += act_val(j * S_MAC + n, i) * wet_val(i, m);
      r[n*8 +: 8] = 8'(s >> sh);
    end
    return r;
  endfunction

  // Writes are expected column-major: m outer, j inner.
  task automatic push_layer(input int sh);
    exp_q.delete();
    for (int m = 0; m < OAW; m++)
      for (int j = 0; j < NB; j++)
        exp_q.push_back({BLK_W'(j), OCOL_W'(m), exp_tile(j, m, sh)});
  endtask

  task automatic push_small_layer(input int sh);
    s_exp_q.delete();
    for (int m = 0; m < S_OAW; m++)
      for (int j = 0; j < S_NB; j++)
        s_exp_q.push_back({S_BLK_W'(j), S_OCOL_W'(m), s_exp_tile(j, m, sh)});
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (outs !== '0) begin errs++; $display("FAIL reset_outs: got %0h expected 0", outs); end
    checks++; if (fsm_state !== IDLE) begin errs++; $display("FAIL reset_state: got %0d expected %0d", fsm_state, IDLE); end
    checks++; if (s_outs !== '0) begin errs++; $display("FAIL reset_outs_small: got %0h expected 0", s_outs); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (outs !== '0) begin errs++; $display("FAIL idle_outs: got %0h expected 0", outs); end
    checks++; if (s_fsm_state !== IDLE) begin errs++; $display("FAIL idle_state_small: got %0d expected %0d", s_fsm_state, IDLE); end
  endtask

  task automatic test_mid_reset();
    int cyc, n_wr;
    logic [EW-1:0] exp_e, got_e;
    push_layer(8);
    shift_num = 8'd8; start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0; n_wr = 0;
    while (cyc < 1000) begin
      @(negedge clk); cyc++;
      if (oa_wr_valid && oa_wr_ready) begin
        n_wr++;
        got_e = {oa_wr_blk, oa_wr_col, oa_wr_data};
        exp_e = exp_q.pop_front();
        checks++; if (got_e !== exp_e) begin errs++; $display("FAIL mid_write: got %0h expected %0h", got_e, exp_e); end
      end
    end
    checks++; if (n_wr != 6) begin errs++; $display("FAIL mid_write_count: got %0d expected 6", n_wr); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (outs !== '0) begin errs++; $display("FAIL mid_reset_outs: got %0h expected 0", outs); end
    checks++; if (fsm_state !== IDLE) begin errs++; $display("FAIL mid_reset_state: got %0d expected %0d", fsm_state, IDLE); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (outs !== '0) begin errs++; $display("FAIL post_reset_outs: got %0h expected 0", outs); end
    exp_q.delete();
  endtask

  // Full layer after the mid-layer reset; also pulses start mid-layer with a
  // different shift value, which must change nothing.
  task automatic test_full_layer();
    int cyc, n_wr, done_cyc, mac_cnt, clr_cnt, overlap;
    logic [EW-1:0] exp_e, got_e;
    push_layer(8);
    shift_num = 8'd8; start = 1'b1;
    @(negedge clk); start = 1'b0; shift_num = 8'd3;
    cyc = 0; n_wr = 0; done_cyc = -1; mac_cnt = 0; clr_cnt = 0; overlap = 0;
    checks++; if (busy !== 1'b1) begin errs++; $display("FAIL busy_after_start: got %0b expected 1", busy); end
    while (done_cyc < 0 && cyc < LAYER_CYC + 200) begin
      @(negedge clk); cyc++;
      if (cyc == 500) start = 1'b1;
      if (cyc == 501) start = 1'b0;
      if (PE_mac_enable) mac_cnt++;
      if (PE_clear_acc) clr_cnt++;
      if (PE_mac_enable && PE_clear_acc) overlap++;
      if (oa_wr_valid && oa_wr_ready) begin
        n_wr++;
        got_e = {oa_wr_blk, oa_wr_col, oa_wr_data};
        checks++;
        if (exp_q.size() == 0) begin
          errs++; $display("FAIL layer_write_extra: got %0h expected none", got_e);
        end else begin
          exp_e = exp_q.pop_front();
          if (got_e !== exp_e) begin errs++; $display("FAIL layer_write %0d: got %0h expected %0h", n_wr, got_e, exp_e); end
        end
        checks++; if (mac_cnt != IAW) begin errs++; $display("FAIL tile_mac_cycles %0d: got %0d expected %0d", n_wr, mac_cnt, IAW); end
        checks++; if (clr_cnt != LAT + 1) begin errs++; $display("FAIL tile_clear_cycles %0d: got %0d expected %0d", n_wr, clr_cnt, LAT + 1); end
        mac_cnt = 0; clr_cnt = 0;
      end
      if (done) done_cyc = cyc;
    end
    checks++; if (done_cyc != LAYER_CYC) begin errs++; $display("FAIL layer_done_cycle: got %0d expected %0d", done_cyc, LAYER_CYC); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL busy_at_done: got %0b expected 0", busy); end
    checks++; if (n_wr != OAW * NB) begin errs++; $display("FAIL layer_write_count: got %0d expected %0d", n_wr, OAW * NB); end
    checks++; if (exp_q.size() != 0) begin errs++; $display("FAIL layer_writes_missing: got %0d left expected 0", exp_q.size()); end
    checks++; if (overlap != 0) begin errs++; $display("FAIL clear_mac_overlap: got %0d expected 0", overlap); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errs++; $display("FAIL done_pulse_width: got %0b expected 0", done); end
    checks++; if (fsm_state !== IDLE) begin errs++; $display("FAIL state_after_done: got %0d expected %0d", fsm_state, IDLE); end
  endtask

  task automatic test_small_order();
    int cyc, n_wr, done_cyc, last_wr;
    logic [S_EW-1:0] exp_e, got_e;
    push_small_layer(2);
    s_shift_num = 8'd2; s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    cyc = 0; n_wr = 0; done_cyc = -1; last_wr = -1;
    while (done_cyc < 0 && cyc < 100) begin
      @(negedge clk); cyc++;
      if (s_oa_wr_valid && s_oa_wr_ready) begin
        got_e = {s_oa_wr_blk, s_oa_wr_col, s_oa_wr_data};
        checks++;
        if (s_exp_q.size() == 0) begin
          errs++; $display("FAIL small_write_extra: got %0h expected none", got_e);
        end else begin
          exp_e = s_exp_q.pop_front();
          if (got_e !== exp_e) begin errs++; $display("FAIL small_write %0d: got %0h expected %0h", n_wr, got_e, exp_e); end
        end
        checks++;
        if (last_wr < 0) begin
          if (cyc != S_TILE_P - 1) begin errs++; $display("FAIL small_first_write: got %0d expected %0d", cyc, S_TILE_P - 1); end
        end else if (cyc - last_wr != S_TILE_P) begin
          errs++; $display("FAIL small_period %0d: got %0d expected %0d", n_wr, cyc - last_wr, S_TILE_P);
        end
        last_wr = cyc; n_wr++;
      end
      if (s_done) done_cyc = cyc;
    end
    checks++; if (n_wr != S_OAW * S_NB) begin errs++; $display("FAIL small_write_count: got %0d expected %0d", n_wr, S_OAW * S_NB); end
    checks++; if (done_cyc != S_OAW * S_NB * S_TILE_P) begin errs++; $display("FAIL small_done_cycle: got %0d expected %0d", done_cyc, S_OAW * S_NB * S_TILE_P); end
    @(negedge clk);
  endtask

  // Hold ready low for 5 cycles when the third tile's write appears.
  task automatic test_stall();
    int cyc, n_wr, done_cyc, last_wr, stall_cnt, exp_gap;
    bit stalling, stall_done;
    logic [S_EW-1:0] exp_e, got_e, held;
    push_small_layer(1);
    s_shift_num = 8'd1; s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    cyc = 0; n_wr = 0; done_cyc = -1; last_wr = -1; stall_cnt = 0;
    stalling = 1'b0; stall_done = 1'b0; held = '0;
    while (done_cyc < 0 && cyc < 100) begin
      @(negedge clk); cyc++;
      got_e = {s_oa_wr_blk, s_oa_wr_col, s_oa_wr_data};
      if (stalling) begin
        checks++; if (s_oa_wr_valid !== 1'b1) begin errs++; $display("FAIL stall_valid_held: got %0b expected 1", s_oa_wr_valid); end
        checks++; if (got_e !== held) begin errs++; $display("FAIL stall_payload_held: got %0h expected %0h", got_e, held); end
        stall_cnt++;
        if (stall_cnt == 5) begin s_oa_wr_ready = 1'b1; stalling = 1'b0; end
      end else if (s_oa_wr_valid && n_wr == 2 && !stall_done) begin
        s_oa_wr_ready = 1'b0; held = got_e; stalling = 1'b1; stall_done = 1'b1;
      end
      if (s_oa_wr_valid && s_oa_wr_ready) begin
        checks++;
        if (s_exp_q.size() == 0) begin
          errs++; $display("FAIL stall_write_extra: got %0h expected none", got_e);
        end else begin
          exp_e = s_exp_q.pop_front();
          if (got_e !== exp_e) begin errs++; $display("FAIL stall_write %0d: got %0h expected %0h", n_wr, got_e, exp_e); end
        end
        if (last_wr >= 0) begin
          exp_gap = (n_wr == 2) ? S_TILE_P + 5 : S_TILE_P;
          checks++; if (cyc - last_wr != exp_gap) begin errs++; $display("FAIL stall_gap %0d: got %0d expected %0d", n_wr, cyc - last_wr, exp_gap); end
        end
        last_wr = cyc; n_wr++;
      end
      if (s_done) done_cyc = cyc;
    end
    s_oa_wr_ready = 1'b1;
    checks++; if (done_cyc != S_OAW * S_NB * S_TILE_P + 5) begin errs++; $display("FAIL stall_done_cycle: got %0d expected %0d", done_cyc, S_OAW * S_NB * S_TILE_P + 5); end
    checks++; if (s_exp_q.size() != 0) begin errs++; $display("FAIL stall_writes_missing: got %0d left expected 0", s_exp_q.size()); end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0; shift_num = '0; oa_wr_ready = 1'b1;
    s_start = 1'b0; s_shift_num = '0; s_oa_wr_ready = 1'b1;
    test_reset();
    test_small_order();
    test_stall();
    test_mid_reset();
    test_full_layer();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
